// File: rtl/pic_tmr_pkg.sv
// rtl/pic_tmr_pkg.sv - OPTION register bit positions and prescaler mask helper
package pic_tmr_pkg;

    localparam int OPT_T0CS  = 5;
    localparam int OPT_T0SE  = 4;
    localparam int OPT_PSA   = 3;
    localparam int OPT_PS_HI = 2;
    localparam int OPT_PS_LO = 0;

    localparam int PS_MASK_W = 16;

    // Low-bit mask of the prescaler that must read all ones for a carry out.
    // TMR0 side uses PS+1 bits (1:2 .. 1:256), WDT side uses PS bits (1:1 .. 1:128).
    function automatic logic [PS_MASK_W-1:0] ps_mask(input logic [2:0] ps, input logic tmr_side);
        logic [3:0] n;
        n = {1'b0, ps} + {3'b000, tmr_side};
        return (PS_MASK_W'(1) << n) - PS_MASK_W'(1);
    endfunction

endpackage

// File: rtl/pic_tmr0_wdt_t0cki_edge.sv
// rtl/pic_tmr0_wdt_t0cki_edge.sv - selectable-edge detector for the TMR0 external count input
module t0cki_edge (
    input  logic clk,
    input  logic rst,
    input  logic t0cki,
    input  logic t0se,
    output logic evt
);

    logic t0cki_q;
    logic t0cki_d;

    // History copy follows the (already synchronous) pin every cycle.
    always_comb begin
        t0cki_d = t0cki;
    end

    // History register.
    always_ff @(posedge clk) begin
        if (rst) begin
            t0cki_q <= 1'b0;
        end else begin
            t0cki_q <= t0cki_d;
        end
    end

    // T0SE=0 counts rising edges, T0SE=1 counts falling edges.
    always_comb begin
        evt = t0se ? (t0cki_q & ~t0cki) : (~t0cki_q & t0cki);
    end

endmodule

// File: rtl/pic_tmr0_wdt.sv
// rtl/pic_tmr0_wdt.sv - TMR0 and watchdog sharing one prescaler; TMR0_IRQ_EN adds the t0if flag
module pic_tmr0_wdt
    import pic_tmr_pkg::*;
#(
    parameter int TMR_W = 8,
    parameter int WDT_W = 10,
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       option,
    input  logic             t0cki,
    input  logic             tmr_wr,
    input  logic [TMR_W-1:0] tmr_wdata,
    input  logic             clrwdt,
    input  logic             sleep,
    input  logic             wdt_tick,
    output logic [TMR_W-1:0] tmr_val,
    output logic             tmr_ovf,
    output logic             wdt_timeout
`ifdef TMR0_IRQ_EN
    ,
    input  logic             t0if_clr,
    output logic             t0if
`endif
);

    logic             t0cs;
    logic             t0se;
    logic             psa;
    logic [2:0]       ps;
    logic [PSC_W-1:0] tmr_mask;
    logic [PSC_W-1:0] wdt_mask;
    logic             edge_evt;

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [WDT_W-1:0] base_q, base_d;
    logic [1:0]       inh_q, inh_d;
    logic             psa_q, psa_d;
    logic             tmr_ovf_q, tmr_ovf_d;
    logic             wdt_timeout_q, wdt_timeout_d;

    logic             src_evt;
    logic             cnt_evt;
    logic             tmr_inc;
    logic             base_ovf;
    logic             wdt_clr;

    assign t0cs     = option[OPT_T0CS];
    assign t0se     = option[OPT_T0SE];
    assign psa      = option[OPT_PSA];
    assign ps       = option[OPT_PS_HI:OPT_PS_LO];
    assign tmr_mask = PSC_W'(ps_mask(ps, 1'b1));
    assign wdt_mask = PSC_W'(ps_mask(ps, 1'b0));

    t0cki_edge u_t0cki_edge (
        .clk   (clk),
        .rst   (rst),
        .t0cki (t0cki),
        .t0se  (t0se),
        .evt   (edge_evt)
    );

    // Next-state for TMR0, the shared prescaler, WDT base counter and write inhibit.
    always_comb begin
        tmr_d         = tmr_q;
        psc_d         = psc_q;
        base_d        = base_q;
        inh_d         = inh_q;
        psa_d         = psa;
        tmr_ovf_d     = 1'b0;
        wdt_timeout_d = 1'b0;

        // While a write is settling the whole TMR0 chain (prescaler included) is frozen.
        src_evt  = t0cs ? edge_evt : 1'b1;
        cnt_evt  = src_evt && (inh_q == 2'd0);
        tmr_inc  = cnt_evt && (psa || ((psc_q & tmr_mask) == tmr_mask));
        base_ovf = wdt_tick && (&base_q);
        wdt_clr  = clrwdt || sleep;

        if (tmr_wr) begin
            tmr_d = tmr_wdata;
            inh_d = 2'd2;
        end else begin
            if (inh_q != 2'd0) begin
                inh_d = inh_q - 2'd1;
            end
            if (tmr_inc) begin
                tmr_d     = tmr_q + TMR_W'(1);
                tmr_ovf_d = &tmr_q;
            end
        end

        if (wdt_clr) begin
            base_d = '0;
        end else if (wdt_tick) begin
            base_d = base_q + WDT_W'(1);
        end
        wdt_timeout_d = !wdt_clr && base_ovf && (!psa || ((psc_q & wdt_mask) == wdt_mask));

        // Reassigning the prescaler always starts it from zero.
        if (psa != psa_q) begin
            psc_d = '0;
        end else if ((!psa && tmr_wr) || (psa && wdt_clr)) begin
            psc_d = '0;
        end else if ((!psa && cnt_evt) || (psa && base_ovf)) begin
            psc_d = psc_q + PSC_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q         <= '0;
            psc_q         <= '0;
            base_q        <= '0;
            inh_q         <= '0;
            psa_q         <= 1'b0;
            tmr_ovf_q     <= 1'b0;
            wdt_timeout_q <= 1'b0;
        end else begin
            tmr_q         <= tmr_d;
            psc_q         <= psc_d;
            base_q        <= base_d;
            inh_q         <= inh_d;
            psa_q         <= psa_d;
            tmr_ovf_q     <= tmr_ovf_d;
            wdt_timeout_q <= wdt_timeout_d;
        end
    end

    assign tmr_val     = tmr_q;
    assign tmr_ovf     = tmr_ovf_q;
    assign wdt_timeout = wdt_timeout_q;

`ifdef TMR0_IRQ_EN
    logic t0if_q, t0if_d;

    // Flag is set by the registered overflow pulse; a set wins over a same-cycle clear.
    always_comb begin
        t0if_d = t0if_q;
        if (tmr_ovf_q) begin
            t0if_d = 1'b1;
        end else if (t0if_clr) begin
            t0if_d = 1'b0;
        end
    end

    // Interrupt flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            t0if_q <= 1'b0;
        end else begin
            t0if_q <= t0if_d;
        end
    end

    assign t0if = t0if_q;
`endif

endmodule
